// File: rtl/wdt_timer.sv
// Watchdog timer: password-protected WDTCTL register, 16-bit interval counter,
// and the strobes that drive the SFR watchdog flag/reset logic.
// Optional build macro WDT_DBG_FREEZE_EN: dbg_freeze holds the counter.
module wdt_timer #(
    parameter logic [8:0] BASE_ADDR = 9'h120,
    parameter logic [7:0] PW_WR     = 8'h5A,
    parameter logic [7:0] PW_RD     = 8'h69
) (
    input  logic        mclk,
    input  logic        puc_n,
    input  logic [7:0]  per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_wen,
    input  logic        wdt_irq_acc,
    input  logic        dbg_freeze,
    output logic [15:0] per_dout,
    output logic        wdtifg_set,
    output logic        wdtifg_clr,
    output logic        wdtpw_error,
    output logic        wdttmsel
);

    localparam int unsigned CNT_W = 16;

    logic             hold_q, hold_d;
    logic             tmsel_q, tmsel_d;
    logic [1:0]       is_q, is_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ifg_set_q, ifg_set_d;
    logic             ifg_clr_q, ifg_clr_d;
    logic             pw_err_q, pw_err_d;

    logic             sel, wr, rd, valid_wr, cntcl_wr, run, term;
    logic [CNT_W-1:0] mask;

    assign sel      = per_en & (per_addr == BASE_ADDR[8:1]);
    assign wr       = sel & (|per_wen);
    assign rd       = sel & ~(|per_wen);
    assign valid_wr = wr & (per_wen == 2'b11) & (per_din[15:8] == PW_WR);
    assign cntcl_wr = valid_wr & per_din[3];

`ifdef WDT_DBG_FREEZE_EN
    logic unused_bits;
    assign run         = ~hold_q & ~dbg_freeze;
    assign unused_bits = &{1'b0, per_din[6:5], per_din[2]};
`else
    logic unused_bits;
    assign run         = ~hold_q;
    assign unused_bits = &{1'b0, per_din[6:5], per_din[2], dbg_freeze};
`endif

    // Low-bit mask of the selected interval; terminal when all masked bits are set.
    always_comb begin
        mask = 16'h7FFF;
        case (is_q)
            2'b00:   mask = 16'h7FFF;
            2'b01:   mask = 16'h1FFF;
            2'b10:   mask = 16'h01FF;
            default: mask = 16'h003F;
        endcase
    end

    assign term = ((cnt_q & mask) == mask);

    // Next-state for control register, counter and strobes.
    always_comb begin
        hold_d    = hold_q;
        tmsel_d   = tmsel_q;
        is_d      = is_q;
        cnt_d     = cnt_q;
        ifg_set_d = 1'b0;
        ifg_clr_d = wdt_irq_acc & tmsel_q;
        pw_err_d  = wr & ~valid_wr;

        if (valid_wr) begin
            hold_d  = per_din[7];
            tmsel_d = per_din[4];
            is_d    = per_din[1:0];
        end

        // A counter clear on the terminal cycle suppresses that expiry.
        if (cntcl_wr) begin
            cnt_d = '0;
        end else if (run) begin
            if (term) begin
                cnt_d     = '0;
                ifg_set_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge mclk or negedge puc_n) begin
        if (!puc_n) begin
            hold_q    <= 1'b0;
            tmsel_q   <= 1'b0;
            is_q      <= 2'b00;
            cnt_q     <= '0;
            ifg_set_q <= 1'b0;
            ifg_clr_q <= 1'b0;
            pw_err_q  <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            tmsel_q   <= tmsel_d;
            is_q      <= is_d;
            cnt_q     <= cnt_d;
            ifg_set_q <= ifg_set_d;
            ifg_clr_q <= ifg_clr_d;
            pw_err_q  <= pw_err_d;
        end
    end

    assign per_dout    = rd ? {PW_RD, hold_q, 2'b00, tmsel_q, 2'b00, is_q} : 16'h0000;
    assign wdtifg_set  = ifg_set_q;
    assign wdtifg_clr  = ifg_clr_q;
    assign wdtpw_error = pw_err_q;
    assign wdttmsel    = tmsel_q;

endmodule

// File: tb/tb_wdt_timer.sv
// Self-checking bench for wdt_timer: directed steps plus a random phase,
// checked against a cycle-level arithmetic model of the watchdog rules.
module tb_wdt_timer;

    logic        mclk = 1'b0;
    logic        puc_n;
    logic [7:0]  per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_wen;
    logic        wdt_irq_acc;
    logic        dbg_freeze;
    logic [15:0] per_dout;
    logic        wdtifg_set, wdtifg_clr, wdtpw_error, wdttmsel;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic       m_hold, m_tmsel;
    logic [1:0] m_is;
    int         m_cnt;

    wdt_timer dut (
        .mclk(mclk), .puc_n(puc_n), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_wen(per_wen), .wdt_irq_acc(wdt_irq_acc),
        .dbg_freeze(dbg_freeze), .per_dout(per_dout), .wdtifg_set(wdtifg_set),
        .wdtifg_clr(wdtifg_clr), .wdtpw_error(wdtpw_error), .wdttmsel(wdttmsel)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int period_of(input logic [1:0] is);
        case (is)
            2'b00:   return 32768;
            2'b01:   return 8192;
            2'b10:   return 512;
            default: return 64;
        endcase
    endfunction

    task automatic model_reset();
        m_hold = 1'b0; m_tmsel = 1'b0; m_is = 2'b00; m_cnt = 0;
    endtask

    // One clock: predict from the current inputs, step the edge, compare strobes.
    task automatic tick();
        logic sel, wr, vw, cl, run, term, frz, e_set, e_err, e_clr;
        int   period;
        sel = per_en && (per_addr == 8'h90);
        wr  = sel && (per_wen != 2'b00);
        vw  = wr && (per_wen == 2'b11) && (per_din[15:8] == 8'h5A);
        cl  = vw && per_din[3];
`ifdef WDT_DBG_FREEZE_EN
        frz = dbg_freeze;
`else
        frz = 1'b0;
`endif
        period = period_of(m_is);
        run    = !m_hold && !frz;
        term   = ((m_cnt + 1) % period) == 0;
        e_set  = run && term && !cl;
        e_err  = wr && !vw;
        e_clr  = wdt_irq_acc && m_tmsel;
        if (cl)       m_cnt = 0;
        else if (run) m_cnt = term ? 0 : m_cnt + 1;
        if (vw) begin
            m_hold = per_din[7]; m_tmsel = per_din[4]; m_is = per_din[1:0];
        end
        @(posedge mclk);
        #1;
        check("ifg_set", 32'(wdtifg_set), 32'(e_set));
        check("pw_err", 32'(wdtpw_error), 32'(e_err));
        check("ifg_clr", 32'(wdtifg_clr), 32'(e_clr));
        check("tmsel", 32'(wdttmsel), 32'(m_tmsel));
    endtask

    task automatic bus_wr(input logic [15:0] din, input logic [1:0] wen);
        per_en = 1'b1; per_addr = 8'h90; per_wen = wen; per_din = din;
        tick();
        per_en = 1'b0; per_wen = 2'b00; per_din = 16'h0000;
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] exp);
        per_en = 1'b1; per_addr = 8'h90; per_wen = 2'b00;
        #1;
        check(tag, 32'(per_dout), 32'(exp));
        check("rd_model", 32'(per_dout), 32'({8'h69, m_hold, 2'b00, m_tmsel, 2'b00, m_is}));
        per_en = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wdtifg_set && n <= limit);
    endtask

    initial begin
        int n, pulses;
        puc_n = 1'b0; per_addr = 8'h00; per_din = 16'h0000; per_en = 1'b0;
        per_wen = 2'b00; wdt_irq_acc = 1'b0; dbg_freeze = 1'b0;
        model_reset();
        #12;
        check("rst_set", 32'(wdtifg_set), 32'd0);
        check("rst_err", 32'(wdtpw_error), 32'd0);
        check("rst_clr", 32'(wdtifg_clr), 32'd0);
        check("rst_tmsel", 32'(wdttmsel), 32'd0);
        check("rst_dout_idle", 32'(per_dout), 32'd0);
        puc_n = 1'b1;

        // Default watchdog interval from reset
        bus_rd("rd_reset", 16'h6900);
        wait_pulse(40000, n);
        check("first_expiry", 32'(n), 32'd32768);

        // Interval mode, shortest interval
        bus_wr(16'h5A1B, 2'b11);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(200, n);
            check("is11_period", 32'(n), 32'd64);
        end
        bus_rd("rd_5a1b", 16'h6913);

        // Unselected read returns zero
        per_en = 1'b1; per_addr = 8'h91; per_wen = 2'b00;
        #1;
        check("rd_unsel", 32'(per_dout), 32'd0);
        per_en = 1'b0;

        // Bad password, then byte-only write
        bus_wr(16'h3A80, 2'b11);
        check("pw_bad", 32'(wdtpw_error), 32'd1);
        tick();
        check("pw_bad_1cyc", 32'(wdtpw_error), 32'd0);
        bus_wr(16'h5A80, 2'b01);
        check("pw_byte", 32'(wdtpw_error), 32'd1);
        tick();
        check("pw_byte_1cyc", 32'(wdtpw_error), 32'd0);
        bus_rd("rd_after_bad", 16'h6913);

        // Hold with clear: no expiry, counter parked at zero
        bus_wr(16'h5A88, 2'b11);
        pulses = 0;
        for (int k = 0; k < 33000; k++) begin
            tick();
            if (wdtifg_set) pulses++;
        end
        check("hold_no_pulse", 32'(pulses), 32'd0);
        bus_wr(16'h5A0B, 2'b11);
        wait_pulse(200, n);
        check("resume_from_zero", 32'(n), 32'd64);

        // Interrupt accept with TMSEL=0, then TMSEL=1
        wdt_irq_acc = 1'b1; tick(); wdt_irq_acc = 1'b0;
        check("clr_tmsel0", 32'(wdtifg_clr), 32'd0);
        bus_wr(16'h5A1B, 2'b11);
        wdt_irq_acc = 1'b1; tick(); wdt_irq_acc = 1'b0;
        check("clr_tmsel1", 32'(wdtifg_clr), 32'd1);
        tick();
        check("clr_1cyc", 32'(wdtifg_clr), 32'd0);

        // Counter clear landing on the terminal cycle
        for (int k = 0; k < 61; k++) tick();
        bus_wr(16'h5A1B, 2'b11);
        check("cntcl_on_term", 32'(wdtifg_set), 32'd0);
        wait_pulse(200, n);
        check("after_cntcl_term", 32'(n), 32'd64);

        // Debug freeze mid-interval
        bus_wr(16'h5A1B, 2'b11);
        for (int k = 0; k < 20; k++) tick();
        dbg_freeze = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        dbg_freeze = 1'b0;
        wait_pulse(200, n);
`ifdef WDT_DBG_FREEZE_EN
        check("freeze_delay", 32'(n + 60), 32'd104);
`else
        check("freeze_ignored", 32'(n + 60), 32'd64);
`endif

        // Random bus traffic against the model
        bus_wr(16'h5A1A, 2'b11);
        for (int k = 0; k < 4000; k++) begin
            per_en      = ($urandom_range(0, 3) == 0);
            per_addr    = ($urandom_range(0, 3) != 0) ? 8'h90 : 8'($urandom);
            per_wen     = 2'($urandom);
            per_din     = {($urandom_range(0, 1) == 1) ? 8'h5A : 8'($urandom), 8'($urandom)};
            wdt_irq_acc = 1'($urandom);
            dbg_freeze  = ($urandom_range(0, 7) == 0);
            tick();
        end
        per_en = 1'b0; per_wen = 2'b00; wdt_irq_acc = 1'b0; dbg_freeze = 1'b0;

        // Asynchronous reset mid-count
        bus_wr(16'h5A1B, 2'b11);
        for (int k = 0; k < 10; k++) tick();
        puc_n = 1'b0;
        #1;
        model_reset();
        check("midrst_tmsel", 32'(wdttmsel), 32'd0);
        check("midrst_set", 32'(wdtifg_set), 32'd0);
        #1;
        puc_n = 1'b1;
        bus_rd("rd_midrst", 16'h6900);
        for (int k = 0; k < 100; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
